// File: rtl/udp_pkg.sv
// Shared definitions for the UDP loopback path: controller state encoding,
// default endpoint identity, frame constants and TX handshake field widths.
package udp_pkg;

   typedef enum logic [4:0] {
      ST_IDLE      = 5'b00001,
      ST_RX_STORE  = 5'b00010,
      ST_RX_COMMIT = 5'b00100,
      ST_TX_REQ    = 5'b01000,
      ST_TX_SEND   = 5'b10000
   } lb_state_t;

   localparam logic [47:0] DEF_MAC     = 48'h00_0A_35_01_FE_C0;
   localparam logic [31:0] DEF_IP      = {8'd192, 8'd168, 8'd1, 8'd10};
   localparam logic [15:0] DEF_PORT    = 16'd1234;
   localparam logic [15:0] ETH_TYPE    = 16'h0800;
   localparam logic [7:0]  IP_PROTOCOL = 8'd17;

   localparam int unsigned LEN_W  = 16;
   localparam int unsigned MAC_W  = 48;
   localparam int unsigned IP_W   = 32;
   localparam int unsigned PORT_W = 16;

   // Add a small increment to a 16-bit statistic, clamping at all-ones.
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, a} + 17'(inc);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/payload_ram.sv
// Payload byte buffer: one write port, one registered read port.
module payload_ram #(
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk_125m,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   logic [7:0] mem [0:(1 << ADDR_W) - 1];

   // Store a byte on the edge the write strobe is sampled.
   always_ff @(posedge clk_125m) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read; output holds between read strobes.
   always_ff @(posedge clk_125m) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/udp_loopback_ctrl.sv
// Loopback sequencer: captures one UDP payload, commits or drops it on the
// receiver verdict, then echoes it through the UDP transmitter.
module udp_loopback_ctrl
   import udp_pkg::*;
#(
   parameter int unsigned ADDR_W     = 11,
   parameter int unsigned TX_TIMEOUT = 4096
) (
   input  logic              clk_125m,
   input  logic              rst,
   input  logic              loop_en,
   input  logic              payload_valid,
   input  logic [7:0]        payload_data,
   input  logic              one_pkt_done,
   input  logic              pkt_err,
   input  logic [MAC_W-1:0]  exter_mac,
   input  logic [IP_W-1:0]   exter_ip,
   input  logic [PORT_W-1:0] exter_port,
   output logic              data_overflow_o,
   output logic              tx_req,
   input  logic              tx_ack,
   output logic [LEN_W-1:0]  tx_len,
   output logic [MAC_W-1:0]  tx_dst_mac,
   output logic [IP_W-1:0]   tx_dst_ip,
   output logic [PORT_W-1:0] tx_dst_port,
   input  logic              tx_data_req,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              busy,
   output logic [15:0]       pkt_fwd_cnt,
   output logic [15:0]       pkt_drop_cnt
);

   localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam int unsigned     TMO_W    = $clog2(TX_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

   lb_state_t        state;
   logic [ADDR_W:0]  wr_addr;
   logic [ADDR_W:0]  rd_addr;
   logic             overflow;
   logic             verdict;
   logic             rd_zero;
   logic [TMO_W-1:0] tmo_cnt;
   logic [7:0]       ram_q;

   logic             in_rx;
   logic             wr_en;
   logic             byte_ovf;
   logic             rd_hit;
   logic             rd_en;
   logic             late_done;
   logic             commit_drop;
   logic             timeout_drop;
   logic [1:0]       drop_inc;

   // Datapath strobes and drop sources derived from the current state.
   always_comb begin
      in_rx        = (state == ST_IDLE) || (state == ST_RX_STORE);
      wr_en        = payload_valid && in_rx && (wr_addr < DEPTH);
      byte_ovf     = payload_valid && (state == ST_RX_STORE) && (wr_addr >= DEPTH);
      rd_hit       = LEN_W'(rd_addr) < tx_len;
      rd_en        = tx_data_req && (state == ST_TX_SEND) && rd_hit;
      late_done    = one_pkt_done && !in_rx;
      commit_drop  = (state == ST_RX_COMMIT) && verdict;
      timeout_drop = (state == ST_TX_SEND) && !tx_done && (tmo_cnt == TMO_LAST);
      drop_inc     = 2'(late_done) + 2'(commit_drop) + 2'(timeout_drop);
   end

   payload_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk_125m (clk_125m),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr[ADDR_W-1:0]),
      .wr_data  (payload_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr[ADDR_W-1:0]),
      .rd_data  (ram_q)
   );

   // Beyond-length reads return zero; the flag and RAM output both hold until the next request.
   assign tx_data         = rd_zero ? 8'h00 : ram_q;
   assign data_overflow_o = overflow;
   assign busy            = (state != ST_IDLE);

   // Sequencer, buffer pointers, TX handshake registers and statistics.
   always_ff @(posedge clk_125m) begin
      if (rst) begin
         state        <= ST_IDLE;
         wr_addr      <= '0;
         rd_addr      <= '0;
         overflow     <= 1'b0;
         verdict      <= 1'b0;
         rd_zero      <= 1'b1;
         tmo_cnt      <= '0;
         tx_req       <= 1'b0;
         tx_len       <= '0;
         tx_dst_mac   <= '0;
         tx_dst_ip    <= '0;
         tx_dst_port  <= '0;
         pkt_fwd_cnt  <= '0;
         pkt_drop_cnt <= '0;
      end else begin
         // Late-packet drops, commit drops and timeout drops can coincide, so they are summed.
         pkt_drop_cnt <= sat_add(pkt_drop_cnt, drop_inc);
         if (wr_en) wr_addr <= wr_addr + (ADDR_W + 1)'(1);
         if (byte_ovf) overflow <= 1'b1;
         if (tx_data_req && (state == ST_TX_SEND)) begin
            rd_zero <= !rd_hit;
            if (rd_hit) rd_addr <= rd_addr + (ADDR_W + 1)'(1);
         end

         case (state)
            ST_IDLE: begin
               if (payload_valid) begin
                  if (one_pkt_done) begin
                     verdict <= pkt_err || !loop_en;
                     state   <= ST_RX_COMMIT;
                  end else begin
                     state   <= ST_RX_STORE;
                  end
               end
            end
            ST_RX_STORE: begin
               if (one_pkt_done) begin
                  verdict <= pkt_err || overflow || byte_ovf || !loop_en;
                  state   <= ST_RX_COMMIT;
               end
            end
            ST_RX_COMMIT: begin
               wr_addr  <= '0;
               overflow <= 1'b0;
               if (verdict) begin
                  state <= ST_IDLE;
               end else begin
                  tx_len      <= LEN_W'(wr_addr);
                  tx_dst_mac  <= exter_mac;
                  tx_dst_ip   <= exter_ip;
                  tx_dst_port <= exter_port;
                  tx_req      <= 1'b1;
                  state       <= ST_TX_REQ;
               end
            end
            ST_TX_REQ: begin
               if (tx_ack) begin
                  tx_req  <= 1'b0;
                  rd_addr <= '0;
                  tmo_cnt <= '0;
                  state   <= ST_TX_SEND;
               end
            end
            ST_TX_SEND: begin
               if (tx_done) begin
                  pkt_fwd_cnt <= sat_add(pkt_fwd_cnt, 2'd1);
                  state       <= ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_loopback_ctrl.sv
// Bench for udp_loopback_ctrl: packet-level reference model updated by the
// stimulus tasks, one per-cycle compare process, plus literal spot checks.
module tb_udp_loopback_ctrl;

   localparam int unsigned AW  = 5;
   localparam int unsigned CAP = 32;
   localparam int unsigned TMO = 100;

   logic        clk_125m = 1'b0;
   logic        rst = 1'b1;
   logic        loop_en = 1'b1;
   logic        payload_valid = 1'b0;
   logic [7:0]  payload_data = '0;
   logic        one_pkt_done = 1'b0;
   logic        pkt_err = 1'b0;
   logic [47:0] exter_mac = '0;
   logic [31:0] exter_ip = '0;
   logic [15:0] exter_port = '0;
   logic        data_overflow_o;
   logic        tx_req;
   logic        tx_ack = 1'b0;
   logic [15:0] tx_len;
   logic [47:0] tx_dst_mac;
   logic [31:0] tx_dst_ip;
   logic [15:0] tx_dst_port;
   logic        tx_data_req = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_done = 1'b0;
   logic        busy;
   logic [15:0] pkt_fwd_cnt;
   logic [15:0] pkt_drop_cnt;

   udp_loopback_ctrl #(.ADDR_W(AW), .TX_TIMEOUT(TMO)) dut (
      .clk_125m(clk_125m), .rst(rst), .loop_en(loop_en),
      .payload_valid(payload_valid), .payload_data(payload_data),
      .one_pkt_done(one_pkt_done), .pkt_err(pkt_err),
      .exter_mac(exter_mac), .exter_ip(exter_ip), .exter_port(exter_port),
      .data_overflow_o(data_overflow_o), .tx_req(tx_req), .tx_ack(tx_ack),
      .tx_len(tx_len), .tx_dst_mac(tx_dst_mac), .tx_dst_ip(tx_dst_ip),
      .tx_dst_port(tx_dst_port), .tx_data_req(tx_data_req), .tx_data(tx_data),
      .tx_done(tx_done), .busy(busy), .pkt_fwd_cnt(pkt_fwd_cnt),
      .pkt_drop_cnt(pkt_drop_cnt)
   );

   always #4 clk_125m = ~clk_125m;

   int checks = 0;
   int errors = 0;

   // reference model: what the outputs must be, per packet-level rules
   logic        exp_busy = 1'b0;
   logic        exp_req = 1'b0;
   logic        exp_ovf = 1'b0;
   logic [15:0] exp_len = '0;
   logic [47:0] exp_mac = '0;
   logic [31:0] exp_ip = '0;
   logic [15:0] exp_port = '0;
   logic [15:0] exp_fwd = '0;
   logic [15:0] exp_drop = '0;
   logic [7:0]  exp_data = '0;
   logic [7:0]  echo_q[$];
   logic        chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic tick();
      @(posedge clk_125m);
      #1;
   endtask

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk_125m) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(exp_busy));
         check("tx_req", 64'(tx_req), 64'(exp_req));
         check("overflow", 64'(data_overflow_o), 64'(exp_ovf));
         check("tx_data", 64'(tx_data), 64'(exp_data));
         check("fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));
         check("drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));
         if (exp_req) begin
            check("tx_len", 64'(tx_len), 64'(exp_len));
            check("tx_dst_mac", 64'(tx_dst_mac), 64'(exp_mac));
            check("tx_dst_ip", 64'(tx_dst_ip), 64'(exp_ip));
            check("tx_dst_port", 64'(tx_dst_port), 64'(exp_port));
         end
      end
   end

   task automatic do_reset();
      payload_valid = 1'b0; one_pkt_done = 1'b0; pkt_err = 1'b0;
      tx_ack = 1'b0; tx_data_req = 1'b0; tx_done = 1'b0;
      rst = 1'b1;
      tick();
      exp_busy = 1'b0; exp_req = 1'b0; exp_ovf = 1'b0; exp_len = '0;
      exp_fwd = '0; exp_drop = '0; exp_data = '0;
      echo_q.delete();
      tick();
      rst = 1'b0;
   endtask

   // deliver one packet to an idle controller; returns whether an echo follows
   task automatic send_pkt(input int len, input bit err, input bit done_last,
                           input bit seq, output bit will_tx);
      int stored = 0;
      bit ovf = 1'b0;
      echo_q.delete();
      for (int i = 0; i < len; i++) begin
         if (i > 0 && $urandom_range(0, 3) == 0) begin
            payload_valid = 1'b0;
            tick();
         end
         payload_valid = 1'b1;
         payload_data  = seq ? 8'(i) : 8'($urandom);
         if (done_last && i == len - 1) begin
            one_pkt_done = 1'b1;
            pkt_err      = err;
         end
         tick();
         exp_busy = 1'b1;
         if (stored < CAP) begin
            echo_q.push_back(payload_data);
            stored++;
         end else begin
            ovf     = 1'b1;
            exp_ovf = 1'b1;
         end
      end
      payload_valid = 1'b0;
      if (!done_last) begin
         if ($urandom_range(0, 1) == 1) tick();
         one_pkt_done = 1'b1;
         pkt_err      = err;
         tick();
      end
      one_pkt_done = 1'b0;
      pkt_err      = 1'b0;
      exter_mac  = {16'($urandom), $urandom};
      exter_ip   = $urandom;
      exter_port = 16'($urandom);
      tick();
      will_tx = !(err || ovf || !loop_en);
      exp_ovf = 1'b0;
      if (!will_tx) begin
         exp_drop = inc16(exp_drop);
         exp_busy = 1'b0;
      end else begin
         exp_req  = 1'b1;
         exp_len  = 16'(stored);
         exp_mac  = exter_mac;
         exp_ip   = exter_ip;
         exp_port = exter_port;
      end
   endtask

   // a packet arriving while the echo is in progress: bytes ignored, done counted as drop
   task automatic intruder();
      int n = $urandom_range(2, 5);
      repeat (2) tick();
      for (int i = 0; i < n; i++) begin
         payload_valid = 1'b1;
         payload_data  = 8'($urandom);
         tick();
      end
      payload_valid = 1'b0;
      one_pkt_done  = 1'b1;
      pkt_err       = 1'($urandom_range(0, 1));
      tick();
      one_pkt_done = 1'b0;
      pkt_err      = 1'b0;
      exp_drop     = inc16(exp_drop);
   endtask

   task automatic pull_bytes(input int extra);
      int idx = 0;
      int total = int'(exp_len) + extra;
      for (int p = 0; p < total; p++) begin
         tx_data_req = 1'b1;
         tick();
         if (idx < int'(exp_len)) begin
            exp_data = echo_q[idx];
            idx++;
         end else begin
            exp_data = 8'h00;
         end
         tx_data_req = 1'b0;
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   // transmitter side: accept the request, pull bytes, finish or let it time out
   task automatic tx_agent(input int ack_delay, input int extra, input bit do_done, input bit intrude);
      repeat (ack_delay) tick();
      tx_ack = 1'b1;
      tick();
      tx_ack  = 1'b0;
      exp_req = 1'b0;
      if (do_done) begin
         fork
            pull_bytes(extra);
            if (intrude) intruder();
         join
         tx_done = 1'b1;
         tick();
         tx_done  = 1'b0;
         exp_fwd  = inc16(exp_fwd);
         exp_busy = 1'b0;
      end else begin
         repeat (TMO - 1) tick();
         check("busy_before_timeout", 64'(busy), 64'd1);
         tick();
         exp_drop = inc16(exp_drop);
         exp_busy = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit will_tx;
      do_reset();
      chk_en = 1'b1;
      check("rst_tx_len", 64'(tx_len), 64'd0);
      check("rst_tx_dst_mac", 64'(tx_dst_mac), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      tick();

      // 18-byte counting payload, good verdict
      send_pkt(18, 1'b0, 1'b0, 1'b1, will_tx);
      check("p1_tx_req", 64'(tx_req), 64'd1);
      check("p1_tx_len", 64'(tx_len), 64'd18);
      tx_agent(1, 0, 1'b1, 1'b0);
      check("p1_last_byte", 64'(tx_data), 64'h11);
      check("p1_fwd", 64'(pkt_fwd_cnt), 64'd1);
      tick();

      // same packet with CRC error
      send_pkt(18, 1'b1, 1'b0, 1'b1, will_tx);
      check("p2_busy", 64'(busy), 64'd0);
      check("p2_drop", 64'(pkt_drop_cnt), 64'd1);
      tick();

      // overflow: 36 bytes into a 32-byte buffer, done on the last byte
      send_pkt(36, 1'b0, 1'b1, 1'b0, will_tx);
      check("p3_drop", 64'(pkt_drop_cnt), 64'd2);
      check("p3_no_req", 64'(tx_req), 64'd0);
      tick();

      // second packet arrives while echoing
      send_pkt(10, 1'b0, 1'b0, 1'b0, will_tx);
      tx_agent(0, 2, 1'b1, 1'b1);
      check("p4_drop", 64'(pkt_drop_cnt), 64'd3);
      check("p4_fwd", 64'(pkt_fwd_cnt), 64'd2);
      tick();

      // transmitter never finishes
      send_pkt(5, 1'b0, 1'b0, 1'b0, will_tx);
      tx_agent(2, 0, 1'b0, 1'b0);
      check("p5_drop", 64'(pkt_drop_cnt), 64'd4);
      check("p5_busy", 64'(busy), 64'd0);

      // header-only packet is ignored
      one_pkt_done = 1'b1;
      tick();
      one_pkt_done = 1'b0;
      repeat (2) tick();
      check("p6_drop", 64'(pkt_drop_cnt), 64'd4);

      // loop disabled: good packet still dropped
      loop_en = 1'b0;
      send_pkt(7, 1'b0, 1'b0, 1'b0, will_tx);
      check("p7_drop", 64'(pkt_drop_cnt), 64'd5);
      loop_en = 1'b1;
      tick();

      // reset mid-capture, then a clean 4-byte packet
      echo_q.delete();
      for (int i = 0; i < 3; i++) begin
         payload_valid = 1'b1;
         payload_data  = 8'($urandom);
         tick();
         exp_busy = 1'b1;
      end
      do_reset();
      tick();
      send_pkt(4, 1'b0, 1'b0, 1'b0, will_tx);
      check("p8_tx_len", 64'(tx_len), 64'd4);
      tx_agent(1, 1, 1'b1, 1'b0);
      check("p8_fwd", 64'(pkt_fwd_cnt), 64'd1);
      check("p8_drop", 64'(pkt_drop_cnt), 64'd0);

      // randomized traffic
      for (int n = 0; n < 30; n++) begin
         int  len = $urandom_range(1, 40);
         bit  err = ($urandom_range(0, 4) == 0);
         bit  dl  = (len >= 2) && ($urandom_range(0, 1) == 1);
         loop_en = ($urandom_range(0, 5) != 0);
         send_pkt(len, err, dl, 1'b0, will_tx);
         if (will_tx)
            tx_agent($urandom_range(0, 3), $urandom_range(0, 2), 1'b1,
                     $urandom_range(0, 3) == 0);
         repeat ($urandom_range(1, 3)) tick();
      end
      loop_en = 1'b1;
      repeat (2) tick();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
